tt_uart_rx_fifo: RTL and testbench
==================================

TT_UART_RX_FIFO -- requirements
Module: tt_uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal values are even and at least 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte entries; the value is fixed at 4 in this revision.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 rx  input  1  asynchronous serial line; idles high.
REQ-006 rd_en  input  1  pops the FIFO head when rd_valid=1.
REQ-007 clr_err  input  1  clears all sticky error flags.
REQ-008 rd_data  output  8  FIFO head byte, first-word-fall-through; drives the ui_in byte of the downstream tt_um_umar316798 core.
REQ-009 rd_valid  output  1  FIFO non-empty.
REQ-010 fifo_count  output  3  entries held, 0..4.
REQ-011 frame_err  output  1  sticky; stop bit was sampled low.
REQ-012 overrun  output  1  sticky; a received byte was dropped because the FIFO was full.
REQ-013 parity_err  output  1  sticky; parity mismatch (see Configuration).

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; all receiver logic SHALL use the synchronized signal.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY (present only with PARITY_EN), STOP.
REQ-016 IDLE->START SHALL occur on a synchronized high-to-low transition.
REQ-017 In START the FSM SHALL sample at CLKS_PER_BIT/2 cycles:
- low -> DATA
- high -> IDLE (false start, no flag set).
REQ-018 DATA SHALL sample 8 bits, LSB first, each CLKS_PER_BIT cycles after the previous sample.
REQ-019 STOP SHALL sample CLKS_PER_BIT cycles after the last data (or parity) sample:
- high -> push the byte
- low -> discard the byte, set frame_err.
In both cases the FSM SHALL return to IDLE.
REQ-020 A pushed byte SHALL appear in the FIFO (rd_valid, fifo_count updated) on the cycle after the stop sample.
REQ-021 A push while fifo_count=4 without a same-cycle pop SHALL drop the new byte and set overrun; stored contents SHALL be unchanged.
REQ-022 A push and a pop in the same cycle SHALL leave fifo_count unchanged and SHALL NOT set overrun, including when full.
REQ-023 rd_en while empty SHALL be ignored; fifo_count SHALL NOT wrap below 0.
REQ-024 Read and write pointers SHALL wrap modulo 4.
REQ-025 rd_data SHALL hold the head entry while rd_valid=1; its value when empty is don't-care.
REQ-026 clr_err SHALL clear all sticky flags on the next edge; an error event in the same cycle SHALL win, leaving its flag set.
REQ-027 After a stop bit the FSM SHALL re-arm in IDLE and accept a back-to-back start bit immediately.

Reset
REQ-028 rst SHALL asynchronously force the following, taking effect mid-frame without completing or pushing the partial byte:
- FSM to IDLE
- FIFO empty: fifo_count=0, rd_valid=0, pointers 0
- rd_data=0
- all sticky flags 0
- synchronizer flops to 1.
REQ-029 After rst deasserts, the first falling edge on rx SHALL be treated as a new start bit.

Configuration
REQ-030 Macro TT_UART_RX_PARITY_EN defined: one even-parity bit follows the data bits and is sampled in PARITY; on mismatch the byte SHALL be discarded and parity_err set; the stop bit is still checked.
REQ-031 Macro undefined: no PARITY state, frame length 10 bits, parity_err tied 0.

Verification (CLKS_PER_BIT=4)
REQ-032 Send 0xA5 as an 8N1 frame -> rd_valid=1, rd_data=0xA5 and fifo_count=1 one cycle after the stop sample; no flags set.
REQ-033 Send five back-to-back frames 0x01..0x05 with no reads -> FIFO holds 0x01..0x04, overrun=1; four pops return 0x01, 0x02, 0x03, 0x04 in order.
REQ-034 Send 0x3C with the stop bit low -> frame_err=1, fifo_count=0; pulse clr_err -> frame_err=0.
REQ-035 Drive a 1-cycle low glitch on rx -> FSM returns to IDLE, no byte pushed, no flags set.
REQ-036 Assert rst during data bit 4 of a frame, then send 0x7E -> only 0x7E is received, fifo_count=1.
REQ-037 With TT_UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 (wrong) -> parity_err=1, byte discarded; resend with parity bit 1 -> rd_data=0x07.

Source files
------------

// File: rtl/tt_uart_rx_fifo.sv
// Purpose : 8N1 UART receiver (optional even parity via TT_UART_RX_PARITY_EN) feeding a 4-entry FWFT byte FIFO.
// Latency : a good byte is visible on rd_data/rd_valid the cycle after its stop-bit sample.
// Backpres: none on rx; a byte arriving while full with no same-cycle pop is dropped and flags overrun.
module tt_uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [2:0] fifo_count,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef TT_UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          push, frame_set;
  logic          rx_meta, rx_sync, rx_prev;
  logic          fall;
`ifdef TT_UART_RX_PARITY_EN
  logic          par_bad, par_bad_nxt, par_set;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [1:0]    wr_ptr, rd_ptr;
  logic          full, pop, wr_ok;

  // Two-flop synchronizer plus one history flop for falling-edge detection; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev & ~rx_sync;

  // Receiver state and bit-timing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef TT_UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
`ifdef TT_UART_RX_PARITY_EN
      par_bad <= par_bad_nxt;
`endif
    end
  end

  // Next-state logic: start is re-checked at mid-bit, later bits sampled one bit period apart.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef TT_UART_RX_PARITY_EN
    par_bad_nxt = par_bad;
    par_set     = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        bit_nxt = '0;
`ifdef TT_UART_RX_PARITY_EN
        par_bad_nxt = 1'b0;
`endif
        if (fall) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          state_nxt = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_sync, shift[7:1]};
          bit_nxt   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef TT_UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef TT_UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = STOP;
          if (rx_sync != ^shift) begin
            par_bad_nxt = 1'b1;
            par_set     = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (!rx_sync) begin
            frame_set = 1'b1;
`ifdef TT_UART_RX_PARITY_EN
          end else if (!par_bad) begin
`else
          end else begin
`endif
            push = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign full     = (fifo_count == 3'd4);
  assign rd_valid = (fifo_count != 3'd0);
  assign pop      = rd_en & rd_valid;
  // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
  assign wr_ok    = push & (~full | pop);
  assign rd_data  = mem[rd_ptr];

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps its flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set | (frame_err & ~clr_err);
      overrun   <= (push & full & ~pop) | (overrun & ~clr_err);
    end
  end

`ifdef TT_UART_RX_PARITY_EN
  // Sticky parity flag, same clear/set priority as the other flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= par_set | (parity_err & ~clr_err);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tt_uart_rx_fifo.sv
// Purpose : directed bench for tt_uart_rx_fifo at CLKS_PER_BIT=4.
// Latency : stop-sample to FIFO visibility checked cycle-exactly on the first frame.
// Backpres: full-FIFO drop, full push+pop and empty pop are each exercised.
module tb_tt_uart_rx_fifo;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef TT_UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  tt_uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    idle(CPB);
  endtask

  // Returns one cycle before the receiver takes its stop sample.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef TT_UART_RX_PARITY_EN
    send_bit(^b ^ par_flip);
`endif
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic pop_one;
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic pulse_clr;
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q [4];
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    idle(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", rd_data, 8'h00);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_perr", parity_err, 0);

    // Single frame, exact visibility cycle
    idle(1);
    send_frame(8'hA5, 1'b1);
    @(negedge clk);
    chk("a5_not_early", rd_valid, 0);
    @(negedge clk);
    chk("a5_valid", rd_valid, 1);
    chk("a5_data", rd_data, 8'hA5);
    chk("a5_count", fifo_count, 1);
    chk("a5_ferr", frame_err, 0);
    chk("a5_ovr", overrun, 0);
    pop_one();
    @(negedge clk);
    chk("a5_popped", fifo_count, 0);

    // Five back-to-back frames into a 4-deep FIFO
    idle(1);
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
    idle(3);
    @(negedge clk);
    chk("ovr_count", fifo_count, 4);
    chk("ovr_flag", overrun, 1);
    chk("ovr_head", rd_data, 8'h01);
    pulse_clr();
    @(negedge clk);
    chk("ovr_cleared", overrun, 0);

    // Full FIFO: pop coincides with the stop sample of a new byte
    idle(1);
    send_frame(8'h06, 1'b1);
    pop_one();
    @(negedge clk);
    chk("pp_count", fifo_count, 4);
    chk("pp_no_ovr", overrun, 0);
    exp_q = '{8'h02, 8'h03, 8'h04, 8'h06};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("drain%0d", i), rd_data, 32'(exp_q[i]));
      pop_one();
    end
    @(negedge clk);
    chk("drain_empty", rd_valid, 0);
    rd_en = 1'b1;
    idle(2);
    rd_en = 1'b0;
    @(negedge clk);
    chk("empty_pop", fifo_count, 0);

    // Stop bit low
    idle(1);
    send_frame(8'h3C, 1'b0);
    idle(2);
    @(negedge clk);
    chk("ferr_set", frame_err, 1);
    chk("ferr_count", fifo_count, 0);
    pulse_clr();
    @(negedge clk);
    chk("ferr_clr", frame_err, 0);
    // Clear in the same cycle as a new framing error: error wins
    idle(1);
    send_frame(8'h3C, 1'b0);
    pulse_clr();
    @(negedge clk);
    chk("ferr_wins", frame_err, 1);
    pulse_clr();
    @(negedge clk);
    chk("ferr_clr2", frame_err, 0);

    // One-cycle glitch is a false start; receiver must still take the next frame
    idle(1);
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(12);
    @(negedge clk);
    chk("glitch_count", fifo_count, 0);
    chk("glitch_ferr", frame_err, 0);
    chk("glitch_ovr", overrun, 0);
    idle(1);
    send_frame(8'h5A, 1'b1);
    idle(2);
    @(negedge clk);
    chk("post_glitch_cnt", fifo_count, 1);
    chk("post_glitch_data", rd_data, 8'h5A);

    // Reset during data bit 4 of 0xC3, then a clean 0x7E
    idle(1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i < 2);
    rx = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(2);
    rx = 1'b1;
    rst = 1'b0;
    idle(5 * CPB);
    @(negedge clk);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_data", rd_data, 8'h00);
    idle(1);
    send_frame(8'h7E, 1'b1);
    idle(2);
    @(negedge clk);
    chk("7e_count", fifo_count, 1);
    chk("7e_data", rd_data, 8'h7E);
    chk("7e_ferr", frame_err, 0);
    pop_one();

`ifdef TT_UART_RX_PARITY_EN
    // Wrong parity then correct parity for 0x07
    par_flip = 1'b1;
    idle(1);
    send_frame(8'h07, 1'b1);
    idle(2);
    @(negedge clk);
    chk("par_err", parity_err, 1);
    chk("par_drop", fifo_count, 0);
    pulse_clr();
    par_flip = 1'b0;
    idle(1);
    send_frame(8'h07, 1'b1);
    idle(2);
    @(negedge clk);
    chk("par_clr", parity_err, 0);
    chk("par_data", rd_data, 8'h07);
    chk("par_count", fifo_count, 1);
`else
    @(negedge clk);
    chk("perr_tied", parity_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
